sound_generator: RTL and testbench

SOUND_GENERATOR -- requirements
Module: sound_generator

---
 rtl/sound_generator.sv | 128 ++++++++++++
 tb/tb_sound_generator.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_generator.sv
// Three-tone sawtooth sound generator driven by game events, with a mute toggle.
// Events preempt tones of equal or lower priority; each tone is a fixed-length ramp.
module sound_generator #(
    parameter int STEP_GOOD = 8,
    parameter int STEP_BAD  = 2,
    parameter int STEP_DIR  = 4,
    parameter int DUR_GOOD  = 512,
    parameter int DUR_BAD   = 768,
    parameter int DUR_DIR   = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button_i,
    input  logic       goodColl_i,
    input  logic       badColl_i,
    input  logic [3:0] direction_i,
    output logic [7:0] soundOut
);

    // Encoding doubles as priority: a larger value wins.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIR  = 2'd1,
        GOOD = 2'd2,
        BAD  = 2'd3
    } state_t;

    typedef enum logic {
        OFF = 1'b0,
        ON  = 1'b1
    } mode_t;

    state_t      state;
    mode_t       mode;
    logic [15:0] timer;
    logic [7:0]  acc;

    logic       button_prev;
    logic       good_prev;
    logic       bad_prev;
    logic [3:0] direction_prev;

    logic   button_ev;
    logic   good_ev;
    logic   bad_ev;
    logic   dir_ev;
    state_t req;
    logic [15:0] req_dur;
    logic [7:0]  cur_step;

    assign button_ev = button_i & ~button_prev;
    assign good_ev   = goodColl_i & ~good_prev;
    assign bad_ev    = badColl_i & ~bad_prev;
    assign dir_ev    = (direction_i != direction_prev) && (direction_i != 4'd0);

    always_comb begin
        req = IDLE;
        if (bad_ev)
            req = BAD;
        else if (good_ev)
            req = GOOD;
        else if (dir_ev)
            req = DIR;
    end

    always_comb begin
        req_dur = 16'd0;
        case (req)
            BAD:     req_dur = 16'(DUR_BAD - 1);
            GOOD:    req_dur = 16'(DUR_GOOD - 1);
            DIR:     req_dur = 16'(DUR_DIR - 1);
            default: req_dur = 16'd0;
        endcase
    end

    always_comb begin
        cur_step = 8'd0;
        case (state)
            BAD:     cur_step = 8'(STEP_BAD);
            GOOD:    cur_step = 8'(STEP_GOOD);
            DIR:     cur_step = 8'(STEP_DIR);
            default: cur_step = 8'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            mode           <= ON;
            timer          <= 16'd0;
            acc            <= 8'd0;
            button_prev    <= 1'b0;
            good_prev      <= 1'b0;
            bad_prev       <= 1'b0;
            direction_prev <= 4'd0;
        end else begin
            // Edge trackers run regardless of mode so held inputs never fire on un-mute.
            button_prev    <= button_i;
            good_prev      <= goodColl_i;
            bad_prev       <= badColl_i;
            direction_prev <= direction_i;

            if (button_ev) begin
                mode  <= (mode == ON) ? OFF : ON;
                state <= IDLE;
                acc   <= 8'd0;
                timer <= 16'd0;
            end else if (mode == ON && req != IDLE && req >= state) begin
                state <= req;
                acc   <= 8'd0;
                timer <= req_dur;
            end else if (state != IDLE) begin
                if (timer == 16'd0) begin
                    state <= IDLE;
                    acc   <= 8'd0;
                end else begin
                    acc   <= acc + cur_step;
                    timer <= timer - 16'd1;
                end
            end else begin
                acc <= 8'd0;
            end
        end
    end

    assign soundOut = acc;

endmodule

// File: tb/tb_sound_generator.sv
// Bench for sound_generator: fixed vector table, directed ramps and resets,
// then random event traffic checked against a tone-age reference model.
module tb_sound_generator;

    logic       clk;
    logic       rst;
    logic       button_i;
    logic       goodColl_i;
    logic       badColl_i;
    logic [3:0] direction_i;
    logic [7:0] soundOut;

    int cnt_cmp;
    int cnt_bad;

    sound_generator dut (
        .clk        (clk),
        .rst        (rst),
        .button_i   (button_i),
        .goodColl_i (goodColl_i),
        .badColl_i  (badColl_i),
        .direction_i(direction_i),
        .soundOut   (soundOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: which tone is playing (0 none, 1 dir, 2 good, 3 bad)
    // and how many cycles since it started.
    bit       m_mode;
    int       m_tone;
    int       m_age;
    bit       p_btn, p_good, p_bad;
    bit [3:0] p_dir;

    function automatic int dur_of(int t);
        case (t)
            1: return 128;
            2: return 512;
            3: return 768;
            default: return 0;
        endcase
    endfunction

    function automatic int step_of(int t);
        case (t)
            1: return 4;
            2: return 8;
            3: return 2;
            default: return 0;
        endcase
    endfunction

    function automatic logic [7:0] model_out();
        if (m_tone == 0)
            return 8'd0;
        return 8'((m_age * step_of(m_tone)) % 256);
    endfunction

    task automatic model_reset();
        m_mode = 1'b1;
        m_tone = 0;
        m_age  = 0;
        p_btn  = 1'b0;
        p_good = 1'b0;
        p_bad  = 1'b0;
        p_dir  = 4'd0;
    endtask

    task automatic model_edge();
        bit be, ge, bde, de;
        int ev;
        be  = button_i && !p_btn;
        ge  = goodColl_i && !p_good;
        bde = badColl_i && !p_bad;
        de  = (direction_i != p_dir) && (direction_i != 4'd0);
        ev  = bde ? 3 : (ge ? 2 : (de ? 1 : 0));
        if (be) begin
            m_tone = 0;
            m_mode = !m_mode;
        end else if (m_mode && ev != 0 && ev >= m_tone) begin
            m_tone = ev;
            m_age  = 0;
        end else if (m_tone != 0) begin
            m_age++;
            if (m_age >= dur_of(m_tone))
                m_tone = 0;
        end
        p_btn  = button_i;
        p_good = goodColl_i;
        p_bad  = badColl_i;
        p_dir  = direction_i;
    endtask

    task automatic check(input string name, input logic [7:0] exp);
        cnt_cmp++;
        if (soundOut !== exp) begin
            cnt_bad++;
            $display("FAIL %s @%0t: soundOut=%0d expected=%0d", name, $time, soundOut, exp);
        end
    endtask

    // Apply inputs, take one rising edge, advance the model, settle 1 time unit.
    task automatic step(input logic b, input logic g, input logic bd, input logic [3:0] d);
        button_i    = b;
        goodColl_i  = g;
        badColl_i   = bd;
        direction_i = d;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    typedef struct {
        logic       b;
        logic       g;
        logic       bd;
        logic [3:0] d;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[21];

    initial begin
        logic       r_b, r_g, r_bd;
        logic [3:0] r_d;
        logic [7:0] exp;

        cnt_cmp = 0;
        cnt_bad = 0;
        button_i = 1'b0; goodColl_i = 1'b0; badColl_i = 1'b0; direction_i = 4'd0;
        rst = 1'b1;
        model_reset();

        tbl[0]  = '{1'b0, 1'b0, 1'b0, 4'd0, 8'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 4'd0, 8'd0};   // good entry
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 4'd0, 8'd8};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 4'd0, 8'd16};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 4'd0, 8'd24};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 4'd0, 8'd0};   // bad preempts good
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 4'd0, 8'd2};   // good ignored during bad
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 4'd1, 8'd4};   // dir ignored during bad
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 4'd1, 8'd0};   // mute
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 4'd1, 8'd0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 4'd1, 8'd0};   // bad while muted
        tbl[11] = '{1'b1, 1'b1, 1'b1, 4'd1, 8'd0};   // un-mute, bad held
        tbl[12] = '{1'b0, 1'b1, 1'b1, 4'd1, 8'd0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 4'd2, 8'd0};   // dir entry
        tbl[14] = '{1'b0, 1'b1, 1'b0, 4'd2, 8'd4};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 4'd0, 8'd8};   // dir to zero: no event
        tbl[16] = '{1'b0, 1'b0, 1'b0, 4'd0, 8'd12};
        tbl[17] = '{1'b0, 1'b1, 1'b1, 4'd0, 8'd0};   // simultaneous -> bad
        tbl[18] = '{1'b0, 1'b1, 1'b1, 4'd0, 8'd2};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 4'd0, 8'd4};
        tbl[20] = '{1'b0, 1'b0, 1'b0, 4'd1, 8'd6};

        // Power-on reset asserted mid-cycle, released away from any edge.
        #3 rst = 1'b0;
        #1 check("por_assert", 8'd0);
        #20 check("por_held", 8'd0);
        #3 rst = 1'b1;
        @(negedge clk);
        check("por_first_negedge", 8'd0);
        #4;

        for (int i = 0; i < 21; i++) begin
            step(tbl[i].b, tbl[i].g, tbl[i].bd, tbl[i].d);
            $display("vec %0d: b=%0b g=%0b bd=%0b d=%b -> %0d (exp %0d)",
                     i, tbl[i].b, tbl[i].g, tbl[i].bd, tbl[i].d, soundOut, tbl[i].exp);
            check($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Drain the remaining bad tone against the model.
        for (int i = 0; i < 800; i++) begin
            step(1'b0, 1'b0, 1'b0, 4'd0);
            check("drain", model_out());
        end

        // Good tone, input held for 5 cycles: full ramp, then silence.
        for (int j = 0; j < 520; j++) begin
            step(1'b0, (j < 5), 1'b0, 4'd0);
            exp = (j < 512) ? 8'((j * 8) % 256) : 8'd0;
            check("good_ramp", exp);
        end
        $display("good tone: 520 cycles checked");

        // Bad pulse: 768-cycle ramp by 2.
        for (int j = 0; j < 775; j++) begin
            step(1'b0, 1'b0, (j == 0), 4'd0);
            exp = (j < 768) ? 8'((j * 2) % 256) : 8'd0;
            check("bad_ramp", exp);
        end
        $display("bad tone: 775 cycles checked");

        // Direction 0000->0001, back to 0000 (silent), then 0001->0010 restart.
        for (int j = 0; j < 132; j++) begin
            step(1'b0, 1'b0, 1'b0, 4'd1);
            exp = (j < 128) ? 8'((j * 4) % 256) : 8'd0;
            check("dir_ramp", exp);
        end
        for (int j = 0; j < 3; j++) begin
            step(1'b0, 1'b0, 1'b0, 4'd0);
            check("dir_zero", 8'd0);
        end
        step(1'b0, 1'b0, 1'b0, 4'd1);
        step(1'b0, 1'b0, 1'b0, 4'd1);
        check("dir_again", 8'd4);
        step(1'b0, 1'b0, 1'b0, 4'd2);
        check("dir_restart", 8'd0);
        step(1'b0, 1'b0, 1'b0, 4'd2);
        check("dir_restart_next", 8'd4);
        $display("direction tone: sequence checked");

        // Mid-tone asynchronous reset.
        step(1'b0, 1'b1, 1'b0, 4'd2);
        for (int j = 0; j < 10; j++)
            step(1'b0, 1'b0, 1'b0, 4'd2);
        check("pre_reset_tone", 8'd80);
        #2 rst = 1'b0;
        #1 check("midtone_reset", 8'd0);
        model_reset();
        @(negedge clk);
        check("midtone_reset_held", 8'd0);
        #2 rst = 1'b1;
        for (int j = 0; j < 3; j++) begin
            step(1'b0, 1'b0, 1'b0, 4'd0);
            check("after_reset", 8'd0);
        end
        $display("mid-tone reset: checked");

        // Random traffic against the model.
        r_b = 1'b0; r_g = 1'b0; r_bd = 1'b0; r_d = 4'd0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 59) == 0) r_b  = ~r_b;
            if ($urandom_range(0, 39) == 0) r_g  = ~r_g;
            if ($urandom_range(0, 69) == 0) r_bd = ~r_bd;
            if ($urandom_range(0, 29) == 0) begin
                case ($urandom_range(0, 4))
                    0: r_d = 4'd0;
                    1: r_d = 4'd1;
                    2: r_d = 4'd2;
                    3: r_d = 4'd4;
                    default: r_d = 4'd8;
                endcase
            end
            step(r_b, r_g, r_bd, r_d);
            check("random", model_out());
        end
        $display("random: 4000 cycles checked");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt_cmp, cnt_bad);
        $finish;
    end

endmodule
